// File: rtl/line_ram_fifo_pkg.sv
// Shared helpers for the line RAM FIFO: pointer width derivation and modular pointer step.
package line_ram_fifo_pkg;

   // Pointer width for a ring of 'size' entries: ceil(log2(size)), never below 1.
   function automatic int unsigned bufferSizeWidth(input int unsigned size);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 5; i++) begin
         if ((32'd1 << w) < size) w = w + 1;
      end
      return w;
   endfunction

   // (ptr + amt) mod size for ptr < size and amt <= 3, size >= 2: two conditional wraps suffice.
   function automatic int unsigned ptrInc(input int unsigned ptr, input int unsigned amt,
                                          input int unsigned size);
      int unsigned sum;
      sum = ptr + amt;
      for (int i = 0; i < 2; i++) begin
         if (sum >= size) sum = sum - size;
      end
      return sum;
   endfunction

endpackage

// File: rtl/line_ram_fifo_if.sv
// Write/read/flow-control bundle between the line producer/consumer and the line RAM FIFO.
interface line_ram_fifo_if
   import line_ram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 16,
   parameter int unsigned ADDRESS_WIDTH     = 11,
   parameter int unsigned BUFFER_SIZE_WIDTH = bufferSizeWidth(4)
);
   logic                         frameClr;
   logic                         wrEn;
   logic [ADDRESS_WIDTH-1:0]     wrAddr;
   logic [DATA_WIDTH-1:0]        wrData;
   logic                         lineDone;
   logic                         jmp1;
   logic                         jmp2;
   logic [ADDRESS_WIDTH-1:0]     ramRdAddr00;
   logic [ADDRESS_WIDTH-1:0]     ramRdAddr01;
   logic [ADDRESS_WIDTH-1:0]     ramRdAddr10;
   logic [ADDRESS_WIDTH-1:0]     ramRdAddr11;
   logic [DATA_WIDTH-1:0]        ramData00;
   logic [DATA_WIDTH-1:0]        ramData01;
   logic [DATA_WIDTH-1:0]        ramData10;
   logic [DATA_WIDTH-1:0]        ramData11;
   logic [BUFFER_SIZE_WIDTH:0]   fifoNum;
   logic                         overflow;

   modport master (
      output frameClr, wrEn, wrAddr, wrData, lineDone, jmp1, jmp2,
      output ramRdAddr00, ramRdAddr01, ramRdAddr10, ramRdAddr11,
      input  ramData00, ramData01, ramData10, ramData11, fifoNum, overflow
   );

   modport slave (
      input  frameClr, wrEn, wrAddr, wrData, lineDone, jmp1, jmp2,
      input  ramRdAddr00, ramRdAddr01, ramRdAddr10, ramRdAddr11,
      output ramData00, ramData01, ramData10, ramData11, fifoNum, overflow
   );
endinterface

// File: rtl/line_ram_fifo_line_ram_dp.sv
// One line RAM: single write port, two synchronous read-first read ports.
module line_ram_dp
   import line_ram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDRESS_WIDTH = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wrEn,
   input  logic [ADDRESS_WIDTH-1:0] wrAddr,
   input  logic [DATA_WIDTH-1:0]    wrData,
   input  logic [ADDRESS_WIDTH-1:0] rdAddrA,
   input  logic [ADDRESS_WIDTH-1:0] rdAddrB,
   output logic [DATA_WIDTH-1:0]    rdDataA,
   output logic [DATA_WIDTH-1:0]    rdDataB
);
   localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage array; not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
   end

   // Registered read ports; same-edge write is not visible until the next read (read-first).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdDataA <= '0;
         rdDataB <= '0;
      end else begin
         rdDataA <= mem[rdAddrA];
         rdDataB <= mem[rdAddrB];
      end
   end
endmodule

// File: rtl/line_ram_fifo.sv
// Ring of line RAMs: producer fills line wrPtr, consumer reads lines rdPtr (A) and rdPtr+1 (B).
module line_ram_fifo
   import line_ram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 16,
   parameter int unsigned ADDRESS_WIDTH     = 11,
   parameter int unsigned BUFFER_SIZE       = 4,
   parameter int unsigned BUFFER_SIZE_WIDTH = bufferSizeWidth(BUFFER_SIZE)
) (
   input  logic            clk,
   input  logic            rst,
   line_ram_fifo_if.slave  bus
);
   localparam int unsigned PW = BUFFER_SIZE_WIDTH;
   localparam int unsigned CW = BUFFER_SIZE_WIDTH + 1;
   localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

   logic [PW-1:0] wrPtr, wrPtrNext;
   logic [PW-1:0] rdPtr, rdPtrNext;
   logic [PW-1:0] rdPtrSel;
   logic [PW-1:0] rdPtrSelB;
   logic [CW-1:0] count, countNext;
   logic          overflow, overflowNext;

   logic [CW-1:0] relAmt;
   logic [CW-1:0] relClamp;
   logic [CW-1:0] countAfter;

   logic [DATA_WIDTH-1:0] ramQa [BUFFER_SIZE];
   logic [DATA_WIDTH-1:0] ramQb [BUFFER_SIZE];

   // Pointer/count next state: release first, then line completion; frameClr overrides both.
   always_comb begin
      relAmt       = bus.jmp2 ? CW'(2) : (bus.jmp1 ? CW'(1) : '0);
      relClamp     = (relAmt > count) ? count : relAmt;
      countAfter   = count - relClamp;
      wrPtrNext    = wrPtr;
      rdPtrNext    = rdPtr;
      countNext    = count;
      overflowNext = overflow;
      if (bus.frameClr) begin
         wrPtrNext = '0;
         rdPtrNext = '0;
         countNext = '0;
      end else begin
         rdPtrNext = PW'(ptrInc(32'(rdPtr), 32'(relClamp), BUFFER_SIZE));
         countNext = countAfter;
         if (bus.lineDone) begin
            wrPtrNext = PW'(ptrInc(32'(wrPtr), 32'd1, BUFFER_SIZE));
            if (countAfter == FULL) begin
               // Ring already full: the new line displaces the oldest one.
               rdPtrNext    = PW'(ptrInc(32'(rdPtr), 32'(relClamp) + 32'd1, BUFFER_SIZE));
               overflowNext = 1'b1;
            end else begin
               countNext = countAfter + CW'(1);
            end
         end
      end
   end

   // State registers; rdPtrSel remembers which line was addressed for the data mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         rdPtrSel <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wrPtr    <= wrPtrNext;
         rdPtr    <= rdPtrNext;
         rdPtrSel <= rdPtr;
         count    <= countNext;
         overflow <= overflowNext;
      end
   end

   for (genvar i = 0; i < BUFFER_SIZE; i++) begin : gLine
      logic                     isLineA;
      logic [ADDRESS_WIDTH-1:0] addrA;
      logic [ADDRESS_WIDTH-1:0] addrB;

      // A RAM serves the 0x addresses while it is line A, otherwise the 1x addresses.
      assign isLineA = (rdPtr == PW'(i));
      assign addrA   = isLineA ? bus.ramRdAddr00 : bus.ramRdAddr10;
      assign addrB   = isLineA ? bus.ramRdAddr01 : bus.ramRdAddr11;

      line_ram_dp #(
         .DATA_WIDTH    (DATA_WIDTH),
         .ADDRESS_WIDTH (ADDRESS_WIDTH)
      ) uRam (
         .clk     (clk),
         .rst     (rst),
         .wrEn    (bus.wrEn && (wrPtr == PW'(i))),
         .wrAddr  (bus.wrAddr),
         .wrData  (bus.wrData),
         .rdAddrA (addrA),
         .rdAddrB (addrB),
         .rdDataA (ramQa[i]),
         .rdDataB (ramQb[i])
      );
   end

   assign rdPtrSelB     = PW'(ptrInc(32'(rdPtrSel), 32'd1, BUFFER_SIZE));
   assign bus.ramData00 = ramQa[rdPtrSel];
   assign bus.ramData01 = ramQb[rdPtrSel];
   assign bus.ramData10 = ramQa[rdPtrSelB];
   assign bus.ramData11 = ramQb[rdPtrSelB];
   assign bus.fifoNum   = count;
   assign bus.overflow  = overflow;
endmodule

// File: tb/tb_line_ram_fifo.sv
// Directed bench for line_ram_fifo: fill, release, overflow, combined events, read-first, clears.
module tb_line_ram_fifo;
   import line_ram_fifo_pkg::*;

   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 11;
   localparam int unsigned BS  = 4;
   localparam int unsigned BSW = 2;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   line_ram_fifo_if #(
      .DATA_WIDTH        (DW),
      .ADDRESS_WIDTH     (AW),
      .BUFFER_SIZE_WIDTH (BSW)
   ) bus ();

   line_ram_fifo #(
      .DATA_WIDTH        (DW),
      .ADDRESS_WIDTH     (AW),
      .BUFFER_SIZE       (BS),
      .BUFFER_SIZE_WIDTH (BSW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write 16 pixels of 'line' (line*256+col), then pulse lineDone (optionally with jmp2).
   task automatic writeLine(input int line, input bit jmp2AtDone);
      for (int c = 0; c < 16; c++) begin
         bus.wrEn   = 1'b1;
         bus.wrAddr = AW'(c);
         bus.wrData = DW'(line * 256 + c);
         step();
      end
      bus.wrEn     = 1'b0;
      bus.lineDone = 1'b1;
      bus.jmp2     = jmp2AtDone;
      step();
      bus.lineDone = 1'b0;
      bus.jmp2     = 1'b0;
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b1;
      bus.frameClr = 1'b0;
      bus.wrEn     = 1'b0;
      bus.wrAddr   = '0;
      bus.wrData   = '0;
      bus.lineDone = 1'b0;
      bus.jmp1     = 1'b0;
      bus.jmp2     = 1'b0;
      bus.ramRdAddr00 = '0;
      bus.ramRdAddr01 = '0;
      bus.ramRdAddr10 = '0;
      bus.ramRdAddr11 = '0;
      step();
      step();
      check("rst_fifoNum", 32'(bus.fifoNum), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_data00", 32'(bus.ramData00), 32'd0);
      check("rst_data11", 32'(bus.ramData11), 32'd0);
      rst = 1'b0;
      step();

      // Three lines into slots 0..2.
      writeLine(0, 1'b0);
      writeLine(1, 1'b0);
      writeLine(2, 1'b0);
      check("fill3_fifoNum", 32'(bus.fifoNum), 32'd3);
      bus.ramRdAddr00 = AW'(5);
      bus.ramRdAddr01 = AW'(3);
      bus.ramRdAddr10 = AW'(5);
      bus.ramRdAddr11 = AW'(9);
      step();
      check("fill3_data00", 32'(bus.ramData00), 32'h0005);
      check("fill3_data01", 32'(bus.ramData01), 32'h0003);
      check("fill3_data10", 32'(bus.ramData10), 32'h0105);
      check("fill3_data11", 32'(bus.ramData11), 32'h0109);

      // Release two lines: line A becomes line 2.
      bus.jmp2 = 1'b1;
      step();
      bus.jmp2 = 1'b0;
      check("jmp2_fifoNum", 32'(bus.fifoNum), 32'd1);
      step();
      check("jmp2_lineA", 32'(bus.ramData00), 32'h0205);

      // Lines 3,4,5 fill to 4; line 6 overwrites slot 2 and drops line 2.
      writeLine(3, 1'b0);
      writeLine(4, 1'b0);
      writeLine(5, 1'b0);
      check("full_fifoNum", 32'(bus.fifoNum), 32'd4);
      check("full_noOverflow", 32'(bus.overflow), 32'd0);
      writeLine(6, 1'b0);
      check("ovf_fifoNum", 32'(bus.fifoNum), 32'd4);
      check("ovf_overflow", 32'(bus.overflow), 32'd1);
      step();
      check("ovf_lineA", 32'(bus.ramData00), 32'h0305);
      check("ovf_lineB", 32'(bus.ramData10), 32'h0405);

      // Down to one line (line 6 in slot 2), then jmp2 together with lineDone.
      bus.jmp2 = 1'b1;
      step();
      bus.jmp2 = 1'b0;
      bus.jmp1 = 1'b1;
      step();
      bus.jmp1 = 1'b0;
      check("one_fifoNum", 32'(bus.fifoNum), 32'd1);
      step();
      check("one_lineA", 32'(bus.ramData00), 32'h0605);
      writeLine(7, 1'b1);
      check("combo_fifoNum", 32'(bus.fifoNum), 32'd1);
      check("combo_rdPtr", 32'(dut.rdPtr), 32'd3);
      step();
      check("combo_lineA", 32'(bus.ramData00), 32'h0705);
      check("combo_overflowSticky", 32'(bus.overflow), 32'd1);

      // frameClr beats jmp1 and lineDone; overflow is kept.
      bus.frameClr = 1'b1;
      bus.jmp1     = 1'b1;
      bus.lineDone = 1'b1;
      step();
      bus.frameClr = 1'b0;
      bus.jmp1     = 1'b0;
      bus.lineDone = 1'b0;
      check("clr_fifoNum", 32'(bus.fifoNum), 32'd0);
      check("clr_wrPtr", 32'(dut.wrPtr), 32'd0);
      check("clr_rdPtr", 32'(dut.rdPtr), 32'd0);
      check("clr_overflow", 32'(bus.overflow), 32'd1);

      // Read-first: slot 0 still holds line 4; write addr 7 while reading it.
      bus.ramRdAddr00 = AW'(7);
      bus.wrEn        = 1'b1;
      bus.wrAddr      = AW'(7);
      bus.wrData      = DW'(16'hABCD);
      step();
      bus.wrEn = 1'b0;
      check("raw_old", 32'(bus.ramData00), 32'h0407);
      step();
      check("raw_new", 32'(bus.ramData00), 32'hABCD);

      // One complete line, then reset in the middle of the next.
      writeLine(8, 1'b0);
      check("pre_rst_fifoNum", 32'(bus.fifoNum), 32'd1);
      for (int c = 0; c < 4; c++) begin
         bus.wrEn   = 1'b1;
         bus.wrAddr = AW'(c);
         bus.wrData = DW'(9 * 256 + c);
         step();
      end
      #2;
      rst      = 1'b1;
      bus.wrEn = 1'b0;
      #1;
      check("mid_rst_fifoNum", 32'(bus.fifoNum), 32'd0);
      check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
      check("mid_rst_data00", 32'(bus.ramData00), 32'd0);
      check("mid_rst_data01", 32'(bus.ramData01), 32'd0);
      check("mid_rst_data10", 32'(bus.ramData10), 32'd0);
      check("mid_rst_data11", 32'(bus.ramData11), 32'd0);
      step();
      rst = 1'b0;
      step();
      bus.lineDone = 1'b1;
      step();
      bus.lineDone = 1'b0;
      check("post_rst_fifoNum", 32'(bus.fifoNum), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/line_ram_fifo.md
LINE_RAM_FIFO -- requirements
Module: line_ram_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 11, line RAM address width; depth 2^ADDRESS_WIDTH.
REQ-003 SHALL have parameter BUFFER_SIZE, default 4, number of line RAMs (2..16).
REQ-004 SHALL have derived parameter BUFFER_SIZE_WIDTH, default 2, pointer width = ceil(log2(BUFFER_SIZE)), minimum 1.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port frameClr, input, 1, synchronous clear of pointers and count at input frame start.
REQ-008 SHALL have port wrEn, input, 1, write strobe from input control.
REQ-009 SHALL have port wrAddr, input, ADDRESS_WIDTH, column address of the write.
REQ-010 SHALL have port wrData, input, DATA_WIDTH, pixel to write.
REQ-011 SHALL have port lineDone, input, 1, one-cycle pulse marking the current write line complete.
REQ-012 SHALL have port jmp1, input, 1, consumer releases one line.
REQ-013 SHALL have port jmp2, input, 1, consumer releases two lines.
REQ-014 SHALL have ports ramRdAddr00, ramRdAddr01, ramRdAddr10, ramRdAddr11, input, ADDRESS_WIDTH each: 0x to line A, 1x to line B.
REQ-015 SHALL have ports ramData00, ramData01, ramData10, ramData11, output, DATA_WIDTH each, read data.
REQ-016 SHALL have port fifoNum, output, BUFFER_SIZE_WIDTH+1, complete unread lines (0..BUFFER_SIZE).
REQ-017 SHALL have port overflow, output, 1, sticky flag for a line dropped while full.

Function
REQ-018 SHALL keep wrPtr, rdPtr (modulo BUFFER_SIZE) and count; fifoNum SHALL equal count, registered.
REQ-019 SHALL write wrData into RAM[wrPtr][wrAddr] on the clk edge where wrEn=1.
REQ-020 SHALL define line A = RAM[rdPtr] and line B = RAM[(rdPtr+1) mod BUFFER_SIZE].
REQ-021 SHALL return read data one cycle after the address, using rdPtr as sampled in the address cycle.
REQ-022 SHALL return old data (read-first) when a read and a write hit the same RAM word in one cycle.
REQ-023 SHALL leave line B data unspecified when count<2; the consumer handles that boundary.
REQ-024 SHALL, on lineDone, advance wrPtr by 1 mod BUFFER_SIZE and increment count.
REQ-025 SHALL compute release amount n = 2 if jmp2=1, else 1 if jmp1=1, else 0; jmp1 and jmp2 both high gives n=2.
REQ-026 SHALL clamp n to count (pre-increment); rdPtr advances by the clamped n mod BUFFER_SIZE and count decreases by it.
REQ-027 SHALL, when lineDone and a release occur in one cycle, give count_next = count + 1 - n_clamped.
REQ-028 SHALL, on lineDone with count=BUFFER_SIZE after release, drop the oldest line: rdPtr advances 1 extra, count stays BUFFER_SIZE, overflow set to 1.
REQ-029 SHALL accept writes while full; they land in slot wrPtr (= rdPtr) and overwrite the oldest line.
REQ-030 SHALL, on frameClr, set wrPtr, rdPtr and count to 0 with priority over lineDone and jmp in the same cycle; frameClr SHALL leave overflow and RAM contents unchanged.

Reset
REQ-031 SHALL, on rst, asynchronously clear wrPtr, rdPtr, count, fifoNum, overflow and the read data registers to 0; RAM contents are not reset.
REQ-032 SHALL, when rst asserts mid-line, discard the partial line; the first lineDone after release gives fifoNum=1.

Structure
REQ-033 SHALL place the BUFFER_SIZE_WIDTH derivation and the pointer-increment-mod function in the shared scaler package.
REQ-034 SHALL instantiate sub-module line_ram_dp (1 write port, 2 synchronous read ports) BUFFER_SIZE times; mux outputs by registered rdPtr.

Verification
REQ-035 SHALL cover: reset, write 3 lines (pixel = line*256+col), 3 lineDone -> fifoNum=3; addr00=5, addr10=5 -> next cycle data00=0x0005, data10=0x0105.
REQ-036 SHALL cover: fifoNum=3, jmp2 pulse -> fifoNum=1, line A = line 2 data.
REQ-037 SHALL cover: fifoNum=4, further lineDone -> fifoNum stays 4, overflow=1, line A = former second line.
REQ-038 SHALL cover: fifoNum=1, jmp2 and lineDone in one cycle -> fifoNum=1, rdPtr advanced 1.
REQ-039 SHALL cover: write addr 7 = 0xABCD while reading addr 7 of the same line -> old value returned that cycle, 0xABCD on the next read.
REQ-040 SHALL cover: frameClr with jmp1 and lineDone -> fifoNum=0, wrPtr=rdPtr=0; rst mid-line -> all outputs 0.
